// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle integer multiply/divide unit holding the HI/LO
// registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset; aborts any operation in flight
//   start  - launch an operation (sampled only while idle)
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU (sampled with start)
//   A, B   - multiplicand/multiplier or dividend/divisor
//   hi_we  - MTHI: load wdata into hi while idle
//   lo_we  - MTLO: load wdata into lo while idle
//   wdata  - MTHI/MTLO data
//   busy   - high from the start edge through the done cycle
//   done   - one-cycle pulse, hi/lo already hold the new result
//   hi, lo - architectural HI/LO registers
//
// One operation takes WIDTH iteration cycles plus one done cycle. Multiply
// is shift-add and divide is restoring shift-subtract; both run on a single
// 2*WIDTH accumulator. Operand magnitudes are latched at start, and the sign
// is applied when the result is written back.

module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_is_div;
  logic               r_neg_q;   // sign of the product or the quotient
  logic               r_neg_r;   // sign of the remainder
  logic [WIDTH-1:0]   r_opnd;    // multiplicand magnitude, or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Launch-time decode
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  // Iteration datapath
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Sign-corrected writeback values
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  always_comb begin
    w_signed = ~op[0];
    w_a_neg  = w_signed & A[WIDTH-1];
    w_b_neg  = w_signed & B[WIDTH-1];
    w_mag_a  = w_a_neg ? -A : A;
    w_mag_b  = w_b_neg ? -B : B;
  end

  always_comb begin
    // Multiply: acc[WIDTH-1:0] holds the remaining multiplier bits; the
    // carry out of the add is shifted back into the top of acc.
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {rem, quo}. The shifted remainder needs one extra bit
    // because the divisor may use all WIDTH bits.
    w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;
    w_div_nxt = w_ge ? {w_rem_sub, r_acc[WIDTH-2:0], 1'b1}
                     : {r_acc[2*WIDTH-2:0], 1'b0};

    w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
  end

  // Writeback uses the value of the final iteration directly, so the
  // result lands on the same edge that completes the last iteration.
  always_comb begin
    w_prod_fix = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    w_quo_fix  = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    w_rem_fix  = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= op[1] & w_a_neg;
            r_cnt    <= '0;
            if (op[1]) begin
              r_opnd <= w_mag_b;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_opnd <= w_mag_a;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end

        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_ITER) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            if (r_is_div) begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and random MULT/MULTU/DIV/DIVU
// operations. Expected {hi,lo} results are queued at issue and checked by an
// independent monitor whenever done is high. The stimulus side also checks
// timing, MTHI/MTLO behaviour, start filtering and mid-operation reset.

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'h0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("result_hi", {32'h0, hi}, {32'h0, e[63:32]});
        chk("result_lo", {32'h0, lo}, {32'h0, e[31:0]});
      end
    end
  end

  // kind: 0 none, 1 second start at cycle ev, 2 MTLO at cycle ev,
  //       3 reset at cycle ev, 4 lo_we together with start.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int ev, input int kind);
    logic [63:0] e;
    int          lat;
    int          busy_cnt;
    bit          aborted;
    lat      = -1;
    busy_cnt = 0;
    aborted  = 1'b0;
    e        = model(o, a, b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    if (kind == 4) begin
      lo_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    if (kind != 3) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    A     = $urandom;
    B     = $urandom;
    for (int k = 0; k <= 40; k++) begin
      if (kind == 1 && k == ev + 1) start = 1'b0;
      if (kind == 2 && k == ev + 1) begin
        lo_we = 1'b0;
        chk("mtlo_in_calc", {32'h0, lo}, {32'h0, cur_lo});
      end
      if (kind == 3 && k == ev + 1) begin
        rst = 1'b0;
        chk("abort_busy", {63'h0, busy}, 64'd0);
        chk("abort_done", {63'h0, done}, 64'd0);
        chk("abort_hi", {32'h0, hi}, 64'd0);
        chk("abort_lo", {32'h0, lo}, 64'd0);
        cur_hi  = '0;
        cur_lo  = '0;
        aborted = 1'b1;
        break;
      end
      if (kind == 4 && k == 0) chk("start_beats_mtlo", {32'h0, lo}, {32'h0, cur_lo});
      if (busy) busy_cnt++;
      if (done && lat < 0) lat = k;
      if (k == 33) begin
        chk("idle_after_done", {63'h0, busy}, 64'd0);
        break;
      end
      if (k == ev) begin
        case (kind)
          1: begin
            start = 1'b1;
            op    = 2'($urandom_range(3, 0));
            A     = $urandom;
            B     = $urandom;
          end
          2: begin
            lo_we = 1'b1;
            wdata = $urandom;
          end
          3: rst = 1'b1;
          default: ;
        endcase
      end
      @(negedge clk);
    end
    if (!aborted) begin
      // done sits in the cycle after edge n+32 (k counts edges after start)
      chk("done_latency", 64'(lat), 64'd32);
      chk("busy_cycles", 64'(busy_cnt), 64'd33);
      {cur_hi, cur_lo} = e;
    end
  endtask

  task automatic check_hl(input string nm, input logic [31:0] eh, input logic [31:0] el);
    chk({nm, "_hi"}, {32'h0, hi}, {32'h0, eh});
    chk({nm, "_lo"}, {32'h0, lo}, {32'h0, el});
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    hi_we = hw;
    lo_we = lw;
    wdata = d;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (hw) cur_hi = d;
    if (lw) cur_lo = d;
    check_hl("mt_write", cur_hi, cur_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    A     = '0;
    B     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'h0, busy}, 64'd0);
    chk("reset_done", {63'h0, done}, 64'd0);
    check_hl("reset", 32'h0, 32'h0);
    rst = 1'b0;

    mt_write(1'b1, 1'b0, 32'h1234_5678);
    mt_write(1'b1, 1'b1, 32'hA5A5_0F0F);

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0);
    check_hl("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, -1, 0);
    check_hl("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, -1, 0);
    check_hl("mult_min", 32'h4000_0000, 32'h0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1, 0);
    check_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(2'd3, 32'd7, 32'd0, -1, 0);
    check_hl("divu_zero", 32'd7, 32'hFFFF_FFFF);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
    check_hl("div_ovf", 32'h0, 32'h8000_0000);
    do_op(2'd2, 32'hFFFF_FFF0, 32'd0, -1, 0);
    check_hl("div_zero_neg", 32'hFFFF_FFF0, 32'h0000_0001);

    do_op(2'd1, 32'h0000_1234, 32'h0000_5678, 10, 1);
    check_hl("second_start", 32'h0, 32'h0626_0060);
    do_op(2'd3, $urandom, $urandom_range(1000, 1), 5, 2);
    do_op(2'd0, 32'd100, 32'hFFFF_FFFE, 0, 4);
    do_op(2'd3, 32'hDEAD_BEEF, 32'd13, 14, 3);
    do_op(2'd1, 32'd6, 32'd7, -1, 0);
    check_hl("multu_after_abort", 32'h0, 32'd42);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      case ($urandom_range(3, 0))
        0: rb = 32'h0;
        1: rb = $urandom_range(16, 1);
        2: rb = -($urandom_range(16, 1));
        default: rb = $urandom;
      endcase
      do_op(2'($urandom_range(3, 0)), ra, rb, -1, 0);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the MIPS150 datapath, covering MULT, MULTU, DIV and DIVU and owning the architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage: the ALU handles every one-cycle operation, while this block takes long-latency operations. It signals `busy` so the hazard logic can stall MFHI/MFLO until `done`. Multiply uses an iterative shift-add datapath; divide uses a restoring shift-subtract datapath. Both share one 64-bit accumulator.

## Interface
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: launch an operation; sampled only in IDLE.
- `op` in 2: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; sampled with `start`.
- `A` in 32: multiplicand or dividend (rs).
- `B` in 32: multiplier or divisor (rt).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: data for MTHI/MTLO.
- `busy` out 1: high in CALC and DONE.
- `done` out 1: one-cycle pulse; HI/LO hold the new result while it is high.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States are IDLE, CALC and DONE.
- IDLE → CALC when `start`=1. On that edge:
  - latch `op`;
  - latch the magnitudes of A and B (two's-complement absolute value for MULT/DIV, raw for the unsigned ops);
  - latch the result sign: MULT uses A[31]^B[31]; DIV uses A[31]^B[31] for the quotient and A[31] for the remainder;
  - clear the accumulator and set iteration counter=0.
- CALC runs exactly 32 iterations, one per cycle, then moves to DONE on the edge that completes iteration 31.
- Multiply iteration: if the multiplier LSB is 1, add the multiplicand to acc[63:32]; then shift {carry, acc} right by 1. The product is 64 bits unsigned.
- Divide iteration: shift {rem, quo} left by 1; if rem ≥ divisor, subtract the divisor and set the quotient LSB. The quotient and remainder are each 32 bits.
- Writeback happens on the CALC→DONE edge:
  - Multiply: {hi, lo} ← the product, negated (64-bit two's complement) when the sign is negative.
  - Divide: lo ← quotient and hi ← remainder, each negated per its own sign. Quotients truncate toward zero.
- DONE lasts one cycle with `done`=1, then returns to IDLE unconditionally.
- Divide by zero (B=0), no exception raised:
  - DIVU: lo=0xFFFFFFFF, hi=A.
  - DIV: lo=0xFFFFFFFF when A≥0 and 0x00000001 when A<0; hi=A. This is the natural result of the sign-fix path.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- MTHI/MTLO: in IDLE, `hi_we` loads `wdata` into hi and `lo_we` loads it into lo; both may fire together.
  - Writes are ignored in CALC and DONE.
  - If `start` and a write occur in the same cycle, `start` wins and the write is dropped.
- `start` is ignored in CALC and DONE. There is no queueing.
- Operands A and B may change after the start edge without affecting the result.

## Timing
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts immediately; no partial HI/LO update occurs.
- Start sampled at edge n:
  - busy=1 from after edge n through the DONE cycle;
  - HI/LO are updated at edge n+32;
  - done=1 for the cycle between edges n+32 and n+33;
  - busy=0 and the unit is in IDLE after edge n+33.
- Latency is 33 cycles from the start edge to the done edge. Back-to-back throughput is one operation per 34 cycles, because `start` is accepted again in the cycle after DONE.
- HI/LO outputs are registered and stable except on the writeback or MTHI/MTLO edges.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → at done: hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after start; busy high for 33 cycles.
- MULT A=0xFFFFFFFD (−3), B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; also MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=7, B=0 → lo=0xFFFFFFFF, hi=7; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Second `start` pulsed 10 cycles into CALC with new operands → ignored; result matches the first operation only; no extra done pulse.
- MTHI wdata=0x12345678 in IDLE → hi updates next edge; MTLO during CALC → lo unchanged until writeback; `start` and `lo_we` in the same cycle → write dropped.
- `rst` asserted 15 cycles into a DIVU → next cycle busy=0, done=0, hi=lo=0; a fresh MULTU 6×7 then yields lo=42, hi=0.
